// File: rtl/rle_vga_pkg.sv
// Shared definitions for the RLE VGA pipeline.
// Holds the flash opcode, stream widths and the SPI reader state encoding.
package rle_vga_pkg;

   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam int         ADDR_BITS = 24;
   localparam int         WORD_BITS = 16;
   localparam int         HDR_BITS  = 32;
   localparam int         CS_GAP    = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT_OUT,
      S_SHIFT_IN,
      S_STALL,
      S_GAP
   } sf_state_t;

endpackage

// File: rtl/spi_flash_stream.sv
// SPI flash READ streamer: sends opcode + 24-bit address, then streams
// 16-bit big-endian words over valid/ready, stalling SCK on backpressure.
// Ports: clk, rst (sync, active-high), start/addr_in/stop control,
// data_out/data_valid/data_ready stream, busy, spi_cs_n/spi_clk/spi_mosi/spi_miso.
module spi_flash_stream
   import rle_vga_pkg::*;
#(
   parameter logic [7:0] CMD_READ = rle_vga_pkg::CMD_READ,
   parameter int         CS_GAP   = rle_vga_pkg::CS_GAP
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_BITS-1:0] addr_in,
   input  logic                 stop,
   output logic [WORD_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 busy,
   output logic                 spi_cs_n,
   output logic                 spi_clk,
   output logic                 spi_mosi,
   input  logic                 spi_miso
);

   sf_state_t               state;
   logic [5:0]              cnt;
   logic [HDR_BITS-1:0]     sr_out;
   logic [WORD_BITS-1:0]    sr_in;
   logic [WORD_BITS-1:0]    word_next;

   // Word including the bit sampled at the end of the current high phase.
   assign word_next = {sr_in[WORD_BITS-2:0], spi_miso};

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         sr_out     <= '0;
         sr_in      <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         busy       <= 1'b0;
         spi_cs_n   <= 1'b1;
         spi_clk    <= 1'b0;
         spi_mosi   <= 1'b0;
      end else if (stop && state != S_IDLE && state != S_GAP) begin
         // Abort: drop CS at once and discard partial/buffered words.
         state      <= S_GAP;
         cnt        <= 6'(CS_GAP - 1);
         data_valid <= 1'b0;
         spi_cs_n   <= 1'b1;
         spi_clk    <= 1'b0;
         spi_mosi   <= 1'b0;
      end else begin
         if (data_valid && data_ready)
            data_valid <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start && !stop) begin
                  state    <= S_SHIFT_OUT;
                  busy     <= 1'b1;
                  cnt      <= '0;
                  spi_cs_n <= 1'b0;
                  spi_clk  <= 1'b0;
                  spi_mosi <= CMD_READ[7];
                  // sr_out[31] always holds the next bit to present.
                  sr_out   <= {CMD_READ[6:0], addr_in, 1'b0};
               end
            end
            S_SHIFT_OUT: begin
               if (!spi_clk) begin
                  spi_clk <= 1'b1;
               end else begin
                  spi_clk <= 1'b0;
                  if (cnt == 6'(HDR_BITS - 1)) begin
                     state    <= S_SHIFT_IN;
                     cnt      <= '0;
                     spi_mosi <= 1'b0;
                  end else begin
                     cnt      <= cnt + 6'd1;
                     spi_mosi <= sr_out[HDR_BITS-1];
                     sr_out   <= {sr_out[HDR_BITS-2:0], 1'b0};
                  end
               end
            end
            S_SHIFT_IN: begin
               if (!spi_clk) begin
                  spi_clk <= 1'b1;
               end else begin
                  spi_clk <= 1'b0;
                  sr_in   <= word_next;
                  if (cnt == 6'(WORD_BITS - 1)) begin
                     cnt <= '0;
                     if (!data_valid || data_ready) begin
                        data_out   <= word_next;
                        data_valid <= 1'b1;
                     end else begin
                        // Buffer full: park with SCK low, word held in sr_in.
                        state <= S_STALL;
                     end
                  end else begin
                     cnt <= cnt + 6'd1;
                  end
               end
            end
            S_STALL: begin
               if (data_ready) begin
                  data_out   <= sr_in;
                  data_valid <= 1'b1;
                  state      <= S_SHIFT_IN;
               end
            end
            S_GAP: begin
               if (cnt == '0) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt - 6'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
